pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_if.sv | 33 +++
 rtl/pc_gen.sv | 119 +++++++++++
 tb/tb_pc_gen.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// pc_gen_if -- redirect/control bundle between the pipeline front end and pc_gen.
//   master : pipeline control side; drives stall and the redirect requests
//            (branch, jump/call, ret, trap) and observes PC and RAS status.
//   slave  : pc_gen; consumes the requests, drives pc_out, pc_plus4,
//            misaligned, ras_underflow, ras_empty and ras_full.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            call;
  logic            ret;
  logic            trap;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus4;
  logic            misaligned;
  logic            ras_underflow;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, call, ret, trap,
    input  pc_out, pc_plus4, misaligned, ras_underflow, ras_empty, ras_full
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, call, ret, trap,
    output pc_out, pc_plus4, misaligned, ras_underflow, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen -- program counter generator with a circular return-address stack.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (PC to RESET_VECTOR, RAS emptied)
//   bus   : pc_gen_if.slave -- redirect requests in; pc_out, pc_plus4,
//           misaligned / ras_underflow pulses and RAS occupancy flags out.
// Next-PC priority: trap, ret, jump, branch, sequential. A misaligned
// ret/jump/branch target diverts to TRAP_VECTOR without touching the RAS.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_gen_if.slave  bus
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  pc_q, pc_d, pc_inc;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [XLEN-1:0]  ras_top;
  logic [PTR_W-1:0] top_q, top_inc, top_dec;
  logic [CNT_W-1:0] cnt_q;
  logic             mis_q, mis_d, unf_q, unf_d;
  logic             push, pop, replace;
  logic             empty, full, do_call;

  assign pc_inc  = pc_q + XLEN'(4);
  assign top_inc = top_q + PTR_W'(1);
  assign top_dec = top_q - PTR_W'(1);
  assign ras_top = ras_mem[top_q];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
  assign do_call = bus.call & bus.jump;

  always_comb begin
    pc_d    = pc_q;
    mis_d   = 1'b0;
    unf_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    replace = 1'b0;
    if (bus.trap) begin
      pc_d = TRAP_VECTOR;
    end else if (!bus.stall) begin
      if (bus.ret) begin
        if (empty) begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
          push  = do_call;
        end else if (ras_top[1:0] != 2'b00) begin
          pc_d  = TRAP_VECTOR;
          mis_d = 1'b1;
        end else begin
          pc_d = ras_top;
          // call+ret: the pop and push cancel, so overwrite the top in place
          if (do_call) replace = 1'b1;
          else         pop     = 1'b1;
        end
      end else if (bus.jump) begin
        if (bus.jump_target[1:0] != 2'b00) begin
          pc_d  = TRAP_VECTOR;
          mis_d = 1'b1;
        end else begin
          pc_d = bus.jump_target;
          push = bus.call;
        end
      end else if (bus.branch_taken) begin
        if (bus.branch_target[1:0] != 2'b00) begin
          pc_d  = TRAP_VECTOR;
          mis_d = 1'b1;
        end else begin
          pc_d = bus.branch_target;
        end
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // Pushing while full advances the pointer onto the oldest slot, which is
  // then overwritten; the count saturates at RAS_DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
      unf_q <= unf_d;
      if (push) begin
        top_q <= top_inc;
        if (!full) cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop) begin
        top_q <= top_dec;
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)         ras_mem[top_inc] <= pc_inc;
    else if (replace) ras_mem[top_q]   <= pc_inc;
  end

  assign bus.pc_out        = pc_q;
  assign bus.pc_plus4      = pc_inc;
  assign bus.misaligned    = mis_q;
  assign bus.ras_underflow = unf_q;
  assign bus.ras_empty     = empty;
  assign bus.ras_full      = full;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam logic [31:0] TRAPV = 32'h0000_0100;
  localparam int unsigned DEPTH = 4;
  localparam int S = 1, T = 2, R = 4, C = 8, J = 16, B = 32;

  typedef struct {
    logic        stall, trap, ret, call, jump, branch;
    logic [31:0] jt, bt;
    logic [31:0] pc;
    logic        mis, unf, emp, full;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_mis = 0;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0),
    .TRAP_VECTOR (TRAPV),
    .RAS_DEPTH   (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference model: PC as a number, RAS as a bounded queue (newest at back)
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_mis, m_unf;

  function automatic vec_t mk(input int ctl, input logic [31:0] jt, input logic [31:0] bt,
                              input logic [31:0] pc, input bit mis, input bit unf,
                              input bit emp, input bit full);
    vec_t v;
    v.stall = (ctl & S) != 0; v.trap = (ctl & T) != 0; v.ret    = (ctl & R) != 0;
    v.call  = (ctl & C) != 0; v.jump = (ctl & J) != 0; v.branch = (ctl & B) != 0;
    v.jt = jt; v.bt = bt; v.pc = pc;
    v.mis = mis; v.unf = unf; v.emp = emp; v.full = full;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.stall = v.stall; bus.trap = v.trap; bus.ret = v.ret; bus.call = v.call;
    bus.jump = v.jump; bus.branch_taken = v.branch;
    bus.jump_target = v.jt; bus.branch_target = v.bt;
  endtask

  task automatic check(input string nm, input logic [31:0] epc, input logic emis,
                       input logic eunf, input logic eemp, input logic efull);
    n_vec++;
    if (bus.pc_out !== epc) begin
      n_mis++; $display("FAIL %s pc_out got %h want %h", nm, bus.pc_out, epc);
    end
    if (bus.pc_plus4 !== epc + 32'd4) begin
      n_mis++; $display("FAIL %s pc_plus4 got %h want %h", nm, bus.pc_plus4, epc + 32'd4);
    end
    if (bus.misaligned !== emis) begin
      n_mis++; $display("FAIL %s misaligned got %b want %b", nm, bus.misaligned, emis);
    end
    if (bus.ras_underflow !== eunf) begin
      n_mis++; $display("FAIL %s ras_underflow got %b want %b", nm, bus.ras_underflow, eunf);
    end
    if (bus.ras_empty !== eemp) begin
      n_mis++; $display("FAIL %s ras_empty got %b want %b", nm, bus.ras_empty, eemp);
    end
    if (bus.ras_full !== efull) begin
      n_mis++; $display("FAIL %s ras_full got %b want %b", nm, bus.ras_full, efull);
    end
  endtask

  function automatic void m_push(input logic [31:0] a);
    m_ras.push_back(a);
    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
  endfunction

  function automatic void model_step(input vec_t v);
    logic [31:0] seq, tgt;
    seq   = m_pc + 32'd4;
    m_mis = 1'b0;
    m_unf = 1'b0;
    if (v.trap) m_pc = TRAPV;
    else if (v.stall) begin
      // everything holds
    end else if (v.ret) begin
      if (m_ras.size() == 0) begin
        m_unf = 1'b1;
        if (v.call && v.jump) m_push(seq);
        m_pc = seq;
      end else begin
        tgt = m_ras[m_ras.size() - 1];
        if (tgt[1:0] != 2'b00) begin
          m_mis = 1'b1; m_pc = TRAPV;
        end else begin
          void'(m_ras.pop_back());
          if (v.call && v.jump) m_push(seq);
          m_pc = tgt;
        end
      end
    end else if (v.jump || v.branch) begin
      tgt = v.jump ? v.jt : v.bt;
      if (tgt[1:0] != 2'b00) begin
        m_mis = 1'b1; m_pc = TRAPV;
      end else begin
        if (v.jump && v.call) m_push(seq);
        m_pc = tgt;
      end
    end else m_pc = seq;
  endfunction

  function automatic logic [31:0] rtgt();
    logic [31:0] t;
    int unsigned r;
    r = $urandom_range(0, 15);
    t = $urandom & 32'h0000_0FFC;
    if (r == 0) t[1:0] = 2'($urandom_range(1, 3));
    else if (r == 1) t = 32'hFFFF_FFF8;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout pc_out got %h want finish", bus.pc_out);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    vec_t idle;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);

    // free run, call/return, stall, misaligned
    tbl.push_back(mk(0, 0, 0, 32'h4, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h8, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'hC, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h10, 0, 0, 1, 0));
    tbl.push_back(mk(J|C, 32'h200, 0, 32'h200, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h204, 0, 0, 0, 0));
    tbl.push_back(mk(R, 0, 0, 32'h14, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h18, 0, 0, 1, 0));
    tbl.push_back(mk(S|B, 0, 32'h40, 32'h18, 0, 0, 1, 0));
    tbl.push_back(mk(S|T, 0, 0, 32'h100, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h104, 0, 0, 1, 0));
    tbl.push_back(mk(J|C, 32'h300, 0, 32'h300, 0, 0, 0, 0));
    tbl.push_back(mk(J|C, 32'h202, 0, 32'h100, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h104, 0, 0, 0, 0));
    tbl.push_back(mk(R, 0, 0, 32'h108, 0, 0, 1, 0));
    tbl.push_back(mk(R, 0, 0, 32'h10C, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h110, 0, 0, 1, 0));
    // five nested calls into a four-deep stack, then five returns
    tbl.push_back(mk(J|C, 32'h1000, 0, 32'h1000, 0, 0, 0, 0));
    tbl.push_back(mk(J|C, 32'h2000, 0, 32'h2000, 0, 0, 0, 0));
    tbl.push_back(mk(J|C, 32'h3000, 0, 32'h3000, 0, 0, 0, 0));
    tbl.push_back(mk(J|C, 32'h4000, 0, 32'h4000, 0, 0, 0, 1));
    tbl.push_back(mk(J|C, 32'h5000, 0, 32'h5000, 0, 0, 0, 1));
    tbl.push_back(mk(R, 0, 0, 32'h4004, 0, 0, 0, 0));
    tbl.push_back(mk(R, 0, 0, 32'h3004, 0, 0, 0, 0));
    tbl.push_back(mk(R, 0, 0, 32'h2004, 0, 0, 0, 0));
    tbl.push_back(mk(R, 0, 0, 32'h1004, 0, 0, 1, 0));
    tbl.push_back(mk(R, 0, 0, 32'h1008, 0, 1, 1, 0));
    // call+ret combined, call without jump, branches, trap keeps the RAS
    tbl.push_back(mk(J|C, 32'h600, 0, 32'h600, 0, 0, 0, 0));
    tbl.push_back(mk(J|C|R, 32'h700, 0, 32'h100C, 0, 0, 0, 0));
    tbl.push_back(mk(R, 0, 0, 32'h604, 0, 0, 1, 0));
    tbl.push_back(mk(J|C|R, 32'h700, 0, 32'h608, 0, 1, 0, 0));
    tbl.push_back(mk(R, 0, 0, 32'h608, 0, 0, 1, 0));
    tbl.push_back(mk(C, 0, 0, 32'h60C, 0, 0, 1, 0));
    tbl.push_back(mk(B, 0, 32'h800, 32'h800, 0, 0, 1, 0));
    tbl.push_back(mk(B, 0, 32'h801, 32'h100, 1, 0, 1, 0));
    tbl.push_back(mk(J|C, 32'h900, 0, 32'h900, 0, 0, 0, 0));
    tbl.push_back(mk(T, 0, 0, 32'h100, 0, 0, 0, 0));
    tbl.push_back(mk(R, 0, 0, 32'h104, 0, 0, 1, 0));
    tbl.push_back(mk(J, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h4, 0, 0, 1, 0));
    tbl.push_back(mk(T|R|J|B, 32'h500, 32'h600, 32'h100, 0, 0, 1, 0));
    tbl.push_back(mk(S|R|J|C, 32'h500, 0, 32'h100, 0, 0, 1, 0));
    tbl.push_back(mk(J|B, 32'hA00, 32'hB00, 32'hA00, 0, 0, 1, 0));

    #2;
    check("reset_state", 32'h0, 0, 0, 1, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i), tbl[i].pc, tbl[i].mis, tbl[i].unf, tbl[i].emp, tbl[i].full);
    end

    // asynchronous reset between edges, held across an edge with trap asserted
    drive(mk(J|C, 32'hC00, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", 32'h0, 0, 0, 1, 0);
    drive(mk(T, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("reset_over_trap", 32'h0, 0, 0, 1, 0);
    #2;
    reset = 1'b0;
    drive(idle);
    @(posedge clk);
    #1;
    check("first_edge_after_reset", 32'h4, 0, 0, 1, 0);

    // reset clears a pending misaligned pulse immediately
    drive(mk(J, 32'h3, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("mis_before_reset", TRAPV, 1, 0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check("mis_cleared_by_reset", 32'h0, 0, 0, 1, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(idle);

    // randomized run against the queue model
    m_pc = 32'h0;
    m_ras.delete();
    for (int n = 0; n < 600; n++) begin
      v.stall  = ($urandom_range(0, 5) == 0);
      v.trap   = ($urandom_range(0, 19) == 0);
      v.ret    = ($urandom_range(0, 4) == 0);
      v.jump   = ($urandom_range(0, 3) == 0);
      v.call   = ($urandom_range(0, 1) == 0);
      v.branch = ($urandom_range(0, 3) == 0);
      v.jt     = rtgt();
      v.bt     = rtgt();
      drive(v);
      @(posedge clk);
      model_step(v);
      #1;
      check($sformatf("rand%0d", n), m_pc, m_mis, m_unf,
            m_ras.size() == 0, m_ras.size() == DEPTH);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
